// File: rtl/thr_ycbcr_multi.sv
// thr_ycbcr_multi: several independent YCbCr threshold windows with a
// one-cycle registered hit mask and saturating per-window hit counters
// that are snapshotted at every frame start.
module thr_ycbcr_multi #(
  parameter int         NUM_WIN    = 4,
  parameter int         CNT_W      = 22,
  parameter bit         VS_POL     = 1'b1,
  parameter logic [7:0] DEF_Y_MIN  = 8'd50,
  parameter logic [7:0] DEF_Y_MAX  = 8'd200,
  parameter logic [7:0] DEF_CB_MIN = 8'd133,
  parameter logic [7:0] DEF_CB_MAX = 8'd173,
  parameter logic [7:0] DEF_CR_MIN = 8'd77,
  parameter logic [7:0] DEF_CR_MAX = 8'd127
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [23:0]              in_data,
  input  logic                     in_hs,
  input  logic                     in_vs,
  input  logic                     in_de,
  input  logic                     cfg_we,
  input  logic [5:0]               cfg_addr,
  input  logic [7:0]               cfg_wdata,
  output logic [NUM_WIN-1:0]       thr_data,
  output logic                     thr_de,
  output logic                     thr_hs,
  output logic                     thr_vs,
  output logic                     cnt_valid,
  output logic [NUM_WIN*CNT_W-1:0] cnt_data
);

  localparam int               NUM_FLD = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reset value of threshold field fld (0..5 = Ymin,Ymax,Cbmin,Cbmax,Crmin,Crmax)
  function automatic logic [7:0] def_thr(input logic [2:0] fld);
    case (fld)
      3'd0:    def_thr = DEF_Y_MIN;
      3'd1:    def_thr = DEF_Y_MAX;
      3'd2:    def_thr = DEF_CB_MIN;
      3'd3:    def_thr = DEF_CB_MAX;
      3'd4:    def_thr = DEF_CR_MIN;
      3'd5:    def_thr = DEF_CR_MAX;
      default: def_thr = 8'd0;
    endcase
  endfunction

  logic [7:0]       shadow_r [NUM_WIN][NUM_FLD];
  logic [7:0]       active_r [NUM_WIN][NUM_FLD];
  logic [CNT_W-1:0] cnt_r    [NUM_WIN];
  logic             vs_q_r;
  logic             vs_armed_r;
  logic             frame_start_s;
  logic             cfg_ok_s;
  logic [NUM_WIN-1:0] hit_s;
  logic [7:0]       y_s;
  logic [7:0]       cb_s;
  logic [7:0]       cr_s;

  assign y_s  = in_data[23:16];
  assign cb_s = in_data[15:8];
  assign cr_s = in_data[7:0];

  // vs_armed_r keeps a vs that is already active when reset releases from
  // looking like a fresh edge against the reset value of vs_q_r.
  assign frame_start_s = (in_vs == VS_POL) && (vs_q_r != VS_POL) && vs_armed_r;
  assign cfg_ok_s      = cfg_we && (int'(cfg_addr[5:3]) < NUM_WIN) && (cfg_addr[2:0] <= 3'd5);

  // Inclusive range test of the current pixel against each window's active set
  always_comb begin
    hit_s = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      hit_s[k] = in_de
        && (y_s  >= active_r[k][0]) && (y_s  <= active_r[k][1])
        && (cb_s >= active_r[k][2]) && (cb_s <= active_r[k][3])
        && (cr_s >= active_r[k][4]) && (cr_s <= active_r[k][5]);
    end
  end

  // Registered vs copy for frame-start edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q_r     <= ~VS_POL;
      vs_armed_r <= 1'b0;
    end else begin
      vs_q_r <= in_vs;
      if (in_vs != VS_POL) begin
        vs_armed_r <= 1'b1;
      end
    end
  end

  // Shadow threshold writes and shadow-to-active transfer at frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_WIN; k++) begin
        for (int f = 0; f < NUM_FLD; f++) begin
          shadow_r[k][f] <= def_thr(3'(f));
          active_r[k][f] <= def_thr(3'(f));
        end
      end
    end else begin
      for (int k = 0; k < NUM_WIN; k++) begin
        for (int f = 0; f < NUM_FLD; f++) begin
          if (cfg_ok_s && (cfg_addr[5:3] == 3'(k)) && (cfg_addr[2:0] == 3'(f))) begin
            shadow_r[k][f] <= cfg_wdata;
          end
          if (frame_start_s) begin
            active_r[k][f] <= shadow_r[k][f];
          end
        end
      end
    end
  end

  // Saturating hit counters, snapshot into cnt_data at each frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
      for (int k = 0; k < NUM_WIN; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      cnt_valid <= frame_start_s;
      for (int k = 0; k < NUM_WIN; k++) begin
        if (frame_start_s) begin
          cnt_data[k*CNT_W +: CNT_W] <= cnt_r[k];
          cnt_r[k] <= hit_s[k] ? CNT_ONE : '0;
        end else if (hit_s[k] && (cnt_r[k] != CNT_MAX)) begin
          cnt_r[k] <= cnt_r[k] + CNT_ONE;
        end
      end
    end
  end

  // One-cycle registered mask and sync outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_data <= '0;
      thr_de   <= 1'b0;
      thr_hs   <= 1'b0;
      thr_vs   <= 1'b0;
    end else begin
      thr_data <= hit_s;
      thr_de   <= in_de;
      thr_hs   <= in_hs;
      thr_vs   <= in_vs;
    end
  end

endmodule
